// File: rtl/video_mode_detect.sv
// Input timing analyser: measures line/frame geometry from HSYNC/VSYNC and
// publishes it once the same geometry has repeated for STABLE_FRAMES frames.
module video_mode_detect #(
    parameter int SYNC_POL      = 0,
    parameter int STABLE_FRAMES = 4,
    parameter int H_TOL         = 2,
    parameter int TIMEOUT       = 4095
) (
    input  logic        PCLK_in,
    input  logic        reset_n,
    input  logic        HSYNC_in,
    input  logic        VSYNC_in,
    output logic [11:0] h_total,
    output logic [7:0]  h_synclen,
    output logic [10:0] v_total,
    output logic [3:0]  v_synclen,
    output logic        stable,
    output logic        mode_changed,
    output logic        sync_lost
);

    localparam logic               ACT = 1'(SYNC_POL);
    localparam logic signed [12:0] TOL = 13'(H_TOL);
    localparam logic [11:0]        TO  = 12'(TIMEOUT);
    localparam logic [3:0]         SF  = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {ST_LOST, ST_ACQUIRE, ST_LOCKED} state_t;
    state_t state;

    function automatic logic [11:0] sat_inc(input logic [11:0] x, input logic [11:0] max);
        return (x >= max) ? max : x + 12'd1;
    endfunction

    function automatic logic signed [12:0] diff13(input logic [11:0] a, input logic [11:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic within_tol(input logic signed [12:0] d);
        return (d <= TOL) && (d >= -TOL);
    endfunction

    logic hs_p0, vs_p0, hs_p1, vs_p1;
    logic h_lead_p1, h_trail_p1, v_lead_p1, v_trail_p1;

    logic [11:0] hcnt, h_meas, cand_h;
    logic [7:0]  hscnt, hs_meas, cand_hs;
    logic [10:0] vlines, cand_v;
    logic [3:0]  vslines, vs_meas, cand_vs, match_cnt;
    logic        armed;

    logic       timeout, is_match;
    logic [3:0] match_inc;

    // p0: sample and normalise sync level; p1: edge flags aligned with the level
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hs_p0      <= 1'b0;
            vs_p0      <= 1'b0;
            hs_p1      <= 1'b0;
            vs_p1      <= 1'b0;
            h_lead_p1  <= 1'b0;
            h_trail_p1 <= 1'b0;
            v_lead_p1  <= 1'b0;
            v_trail_p1 <= 1'b0;
        end else begin
            hs_p0      <= (HSYNC_in == ACT);
            vs_p0      <= (VSYNC_in == ACT);
            hs_p1      <= hs_p0;
            vs_p1      <= vs_p0;
            h_lead_p1  <= hs_p0 & ~hs_p1;
            h_trail_p1 <= ~hs_p0 & hs_p1;
            v_lead_p1  <= vs_p0 & ~vs_p1;
            v_trail_p1 <= ~vs_p0 & vs_p1;
        end
    end

    assign timeout   = (state != ST_LOST) && ((hcnt == TO) || (vlines == 11'h7FF));
    assign match_inc = match_cnt + 4'd1;
    // At a frame event vlines already excludes a coincident HSYNC edge, so it is the frame length
    assign is_match  = within_tol(diff13(h_meas, cand_h))
                    && within_tol(diff13({4'd0, hs_meas}, {4'd0, cand_hs}))
                    && (diff13({1'b0, vlines}, {1'b0, cand_v}) == 13'sd0);

    // p2: line and frame counters
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt    <= '0;
            hscnt   <= '0;
            vlines  <= '0;
            vslines <= '0;
            h_meas  <= '0;
            hs_meas <= '0;
            vs_meas <= '0;
        end else begin
            if (h_lead_p1) begin
                hcnt   <= '0;
                hscnt  <= '0;
                h_meas <= sat_inc(hcnt, 12'hFFF);
            end else begin
                hcnt <= sat_inc(hcnt, 12'hFFF);
                if (hs_p1)
                    hscnt <= 8'(sat_inc({4'd0, hscnt}, 12'd255));
            end
            if (h_trail_p1)
                hs_meas <= 8'(sat_inc({4'd0, hscnt}, 12'd255));

            if (state == ST_LOST || timeout)
                vlines <= '0;
            else if (v_lead_p1)
                vlines <= h_lead_p1 ? 11'd1 : 11'd0;
            else if (h_lead_p1)
                vlines <= 11'(sat_inc({1'b0, vlines}, 12'd2047));

            if (v_lead_p1)
                vslines <= h_lead_p1 ? 4'd1 : 4'd0;
            else if (h_lead_p1 && vs_p1)
                vslines <= 4'(sat_inc({8'd0, vslines}, 12'd15));
            if (v_trail_p1)
                vs_meas <= vslines;
        end
    end

    // p3: lock state machine and published outputs
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_LOST;
            armed        <= 1'b0;
            match_cnt    <= '0;
            cand_h       <= '0;
            cand_hs      <= '0;
            cand_v       <= '0;
            cand_vs      <= '0;
            h_total      <= '0;
            h_synclen    <= '0;
            v_total      <= '0;
            v_synclen    <= '0;
            stable       <= 1'b0;
            mode_changed <= 1'b0;
            sync_lost    <= 1'b1;
        end else begin
            mode_changed <= 1'b0;
            if (timeout) begin
                state     <= ST_LOST;
                match_cnt <= '0;
                h_total   <= '0;
                h_synclen <= '0;
                v_total   <= '0;
                v_synclen <= '0;
                stable    <= 1'b0;
                sync_lost <= 1'b1;
            end else begin
                case (state)
                    ST_LOST: begin
                        if (h_lead_p1) begin
                            state     <= ST_ACQUIRE;
                            armed     <= 1'b0;
                            sync_lost <= 1'b0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (v_lead_p1) begin
                            if (!armed) begin
                                armed <= 1'b1;
                            end else if (is_match) begin
                                match_cnt <= match_inc;
                                if (match_inc == SF) begin
                                    state        <= ST_LOCKED;
                                    stable       <= 1'b1;
                                    mode_changed <= 1'b1;
                                    h_total      <= cand_h;
                                    h_synclen    <= cand_hs;
                                    v_total      <= cand_v;
                                    v_synclen    <= cand_vs;
                                end
                            end else begin
                                cand_h    <= h_meas;
                                cand_hs   <= hs_meas;
                                cand_v    <= vlines;
                                cand_vs   <= vs_meas;
                                match_cnt <= 4'd1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (v_lead_p1 && !is_match) begin
                            state     <= ST_ACQUIRE;
                            stable    <= 1'b0;
                            cand_h    <= h_meas;
                            cand_hs   <= hs_meas;
                            cand_v    <= vlines;
                            cand_vs   <= vs_meas;
                            match_cnt <= 4'd1;
                        end
                    end
                    default: state <= ST_LOST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench for video_mode_detect on a scaled-down raster (40-cycle lines,
// 26-line frames) so each lock sequence stays short; lock payloads go through a scoreboard.
module tb_video_mode_detect;

    localparam int P    = 40;
    localparam int HW   = 6;
    localparam int NL   = 26;
    localparam int VW   = 3;
    localparam int VOFF = 20;

    logic        PCLK_in;
    logic        reset_n;
    logic        HSYNC_in;
    logic        VSYNC_in;
    logic [11:0] h_total;
    logic [7:0]  h_synclen;
    logic [10:0] v_total;
    logic [3:0]  v_synclen;
    logic        stable;
    logic        mode_changed;
    logic        sync_lost;

    video_mode_detect dut (
        .PCLK_in      (PCLK_in),
        .reset_n      (reset_n),
        .HSYNC_in     (HSYNC_in),
        .VSYNC_in     (VSYNC_in),
        .h_total      (h_total),
        .h_synclen    (h_synclen),
        .v_total      (v_total),
        .v_synclen    (v_synclen),
        .stable       (stable),
        .mode_changed (mode_changed),
        .sync_lost    (sync_lost)
    );

    initial PCLK_in = 1'b0;
    always #5 PCLK_in = ~PCLK_in;

    typedef struct {
        int h;
        int hs;
        int v;
        int vs;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    logic mc_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Each mode_changed pulse must be single-cycle and match the oldest pending lock
    always @(negedge PCLK_in) begin
        if (mode_changed) begin
            check("mc_width", 32'(mc_prev), 0);
            check("mc_pending", 32'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("lock_h_total", 32'(h_total), e.h);
                check("lock_h_synclen", 32'(h_synclen), e.hs);
                check("lock_v_total", 32'(v_total), e.v);
                check("lock_v_synclen", 32'(v_synclen), e.vs);
                check("lock_stable", 32'(stable), 1);
            end
        end
        mc_prev <= mode_changed;
    end

    // Sync is active-low; vsync asserts at line 0 and releases at line VW, both at cycle voff
    task automatic frame(input int nl, input int jit, input int last_p, input int voff);
        int p;
        for (int l = 0; l < nl; l++) begin
            p = P;
            if (jit != 0) p = (l % 2 != 0) ? P + 1 : P - 1;
            if (l == nl - 1 && last_p != 0) p = last_p;
            for (int c = 0; c < p; c++) begin
                @(negedge PCLK_in);
                HSYNC_in = (c < HW) ? 1'b0 : 1'b1;
                if (l == 0 && c == voff) VSYNC_in = 1'b0;
                if (l == VW && c == voff) VSYNC_in = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK_in);
            HSYNC_in = 1'b1;
            VSYNC_in = 1'b1;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_stable"}, 32'(stable), 0);
        check({tag, "_sync_lost"}, 32'(sync_lost), 1);
        check({tag, "_h_total"}, 32'(h_total), 0);
        check({tag, "_h_synclen"}, 32'(h_synclen), 0);
        check({tag, "_v_total"}, 32'(v_total), 0);
        check({tag, "_v_synclen"}, 32'(v_synclen), 0);
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        HSYNC_in = 1'b1;
        VSYNC_in = 1'b1;
        repeat (3) @(negedge PCLK_in);
        check_cleared("reset");
        check("reset_mode_changed", 32'(mode_changed), 0);
        reset_n = 1'b1;
        idle(5);

        // Nominal acquisition: arm on edge 1, lock on edge 5
        sbq.push_back('{P, HW, NL, VW});
        repeat (4) frame(NL, 0, 0, VOFF);
        check("nom_stable_after4", 32'(stable), 0);
        check("nom_sync_lost", 32'(sync_lost), 0);
        frame(NL, 0, 0, VOFF);
        check("nom_stable_after5", 32'(stable), 1);
        check("nom_h_total", 32'(h_total), P);
        check("nom_v_total", 32'(v_total), NL);

        // Alternating P-1/P+1 lines stay inside tolerance
        repeat (3) frame(NL, 1, 0, VOFF);
        check("jit_stable", 32'(stable), 1);

        // One long line just before a vsync edge breaks lock; outputs hold
        frame(NL, 0, P + 6, VOFF);
        frame(NL, 0, 0, VOFF);
        check("spike_stable", 32'(stable), 0);
        check("spike_hold_h_total", 32'(h_total), P);
        check("spike_hold_h_synclen", 32'(h_synclen), HW);
        check("spike_hold_v_total", 32'(v_total), NL);
        check("spike_hold_v_synclen", 32'(v_synclen), VW);
        sbq.push_back('{P, HW, NL, VW});
        repeat (4) frame(NL, 0, 0, VOFF);
        check("spike_relock", 32'(stable), 1);

        // Mode switch to one more line per frame
        frame(NL + 1, 0, 0, VOFF);
        check("mode_first_still_locked", 32'(stable), 1);
        frame(NL + 1, 0, 0, VOFF);
        check("mode_drop", 32'(stable), 0);
        check("mode_hold_v_total", 32'(v_total), NL);
        sbq.push_back('{P, HW, NL + 1, VW});
        repeat (3) frame(NL + 1, 0, 0, VOFF);
        check("mode_relock", 32'(stable), 1);
        check("mode_v_total", 32'(v_total), NL + 1);

        // HSYNC stops: sync_lost after TIMEOUT cycles without an edge
        n = 0;
        HSYNC_in = 1'b1;
        VSYNC_in = 1'b1;
        while (!sync_lost && n < 5000) begin
            @(negedge PCLK_in);
            n++;
        end
        check("to_window", 32'(n >= 4000 && n <= 4100), 1);
        check_cleared("to");
        sbq.push_back('{P, HW, NL, VW});
        repeat (5) frame(NL, 0, 0, VOFF);
        check("to_relock", 32'(stable), 1);
        check("to_relock_h_synclen", 32'(h_synclen), HW);

        // Asynchronous reset mid-frame while locked
        frame(5, 0, 0, VOFF);
        check("rst_pre_stable", 32'(stable), 1);
        #2 reset_n = 1'b0;
        #1 check_cleared("rst_async");
        check("rst_async_mode_changed", 32'(mode_changed), 0);
        idle(2);
        reset_n = 1'b1;
        idle(5);
        sbq.push_back('{P, HW, NL, VW});
        repeat (4) frame(NL, 0, 0, VOFF);
        check("rst_stable_after4", 32'(stable), 0);
        frame(NL, 0, 0, VOFF);
        check("rst_relock", 32'(stable), 1);

        // Vsync and hsync edges coincide: transition frame reads one line short
        frame(NL, 0, 0, 0);
        check("coin_transition_drop", 32'(stable), 0);
        sbq.push_back('{P, HW, NL, VW});
        repeat (4) frame(NL, 0, 0, 0);
        check("coin_relock", 32'(stable), 1);
        check("coin_v_total", 32'(v_total), NL);
        check("coin_v_synclen", 32'(v_synclen), VW);

        idle(10);
        check("sb_drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_mode_detect.md
# video_mode_detect

Input timing analyser for the incoming CPS2 video, clocked by the latched-input pixel clock alongside the scanconverter. It measures the line period and sync width from HSYNC_in, and the frame length and vsync width from VSYNC_in. It publishes these values only after they have repeated for a configurable number of frames. The sys CPU reads the published values through a PIO, uses them to program the syncgen h_info/v_info words, and reacts to loss of lock or to a mode change.

## Interface
Parameters:
- SYNC_POL, 0: sync active level; 0 = active-low (CPS2), 1 = active-high
- STABLE_FRAMES, 4: consecutive matching frames required for lock (2..15)
- H_TOL, 2: allowed line-period deviation in PCLK_in cycles when comparing frames
- TIMEOUT, 4095: PCLK_in cycles without a HSYNC leading edge before sync is declared lost (≤4095)

Ports:
- PCLK_in  in  1  pixel clock; all logic is on its posedge
- reset_n  in  1  asynchronous, active-low reset
- HSYNC_in  in  1  horizontal sync, already synchronous to PCLK_in
- VSYNC_in  in  1  vertical sync, already synchronous to PCLK_in
- h_total  out  12  published line period in PCLK_in cycles
- h_synclen  out  8  published hsync width in PCLK_in cycles
- v_total  out  11  published frame length in lines
- v_synclen  out  4  published vsync width in lines
- stable  out  1  high while in state LOCKED
- mode_changed  out  1  one-cycle pulse on every ACQUIRE→LOCKED transition
- sync_lost  out  1  high while in state LOST

## Operation
- Edge detection:
  - Each sync input is registered once, and the level is normalised by SYNC_POL.
  - A leading edge is previous-inactive and current-active; a trailing edge is the reverse.
- hcnt (12 bit):
  - Cleared on a HSYNC leading edge, otherwise incremented; saturates at 4095.
  - On a leading edge, h_meas ← hcnt+1.
- hscnt (8 bit):
  - Cleared on a HSYNC leading edge, incremented while HSYNC is active, saturates at 255.
  - On a trailing edge, hs_meas ← hscnt+1.
- vlines (11 bit):
  - Incremented on each HSYNC leading edge; saturates at 2047.
  - On a VSYNC leading edge, v_meas ← vlines and vlines is reset to 0.
  - If a HSYNC leading edge falls in the same cycle as the VSYNC leading edge, that line is counted into the new frame: v_meas excludes it and vlines ← 1.
- vslines (4 bit):
  - Counts HSYNC leading edges while VSYNC is active, saturates at 15.
  - On a VSYNC trailing edge, vs_meas ← vslines.
- Frame event: a VSYNC leading edge. The first frame event after leaving LOST only arms the measurement (the frame is partial) and is not compared.
- Match rule:
  - |h_meas − cand_h| ≤ H_TOL, v_meas == cand_v, and hs_meas == cand_hs ± H_TOL.
  - Each comparison is computed with 13-bit signed differences.
- Candidate registers cand_h, cand_hs, cand_v, cand_vs and a 4-bit match_cnt.
- LOST (reset state):
  - Outputs h_total, h_synclen, v_total and v_synclen are 0.
  - The first HSYNC leading edge moves to ACQUIRE with arming pending.
- ACQUIRE, on each armed frame event:
  - On a match, match_cnt increments.
  - On a mismatch, the candidate registers load the current measurements and match_cnt ← 1.
  - When the incremented match_cnt equals STABLE_FRAMES: publish the candidate to the outputs, go to LOCKED, and pulse mode_changed.
- LOCKED, on each frame event:
  - On a match, hold everything.
  - On a mismatch, go to ACQUIRE, load the candidate from the current measurements, and set match_cnt ← 1.
  - Published outputs hold their last values until the next lock.
- Timeout (any state except LOST): hcnt reaching TIMEOUT, or vlines saturating at 2047, forces LOST. LOST clears the published outputs and match_cnt.
- Timeout and a frame event in the same cycle: the timeout wins.

## Timing
- Reset values: all four published outputs 0, stable=0, mode_changed=0, sync_lost=1, state LOST, all counters 0.
- Input-to-detect latency: a sync transition on the input at posedge k is detected at posedge k+1. Resulting register updates are visible after posedge k+2.
- The lock transition, published values, stable and mode_changed are all updated on the same edge, one cycle after the detecting cycle.
- mode_changed is high for exactly one PCLK_in cycle.
- Asserting reset_n low mid-frame immediately forces the reset values; no partial publish occurs.

## Test plan
- Nominal CPS2 timing: h period 1024, hsync width 72, 262 lines/frame, vsync width 3, STABLE_FRAMES=4. Required: stable rises after the 5th VSYNC leading edge (1 arming + 4 matches). Outputs 1024/72/262/3; a single mode_changed pulse.
- Jitter: line period alternating 1023/1025 with H_TOL=2 → stays LOCKED, no extra pulse. A single line at 1030 before a vsync edge → drops to ACQUIRE, stable=0, outputs hold 1024/72/262/3.
- Mode switch from 262 to 263 lines → ACQUIRE at the first differing frame. Relock after 4 frames with v_total=263 and one mode_changed pulse.
- HSYNC stopped while LOCKED → after 4095 cycles without an edge: sync_lost=1, stable=0, outputs 0. Restoring sync relocks within 5 frames.
- VSYNC and HSYNC leading edges in the same cycle every frame → v_total=262 (not 261 or 263).
- reset_n pulsed low mid-frame while LOCKED → asynchronous clear to the reset values. Relock follows the nominal sequence.
